mulxx_seq: RTL and testbench
============================

Name: mulxx_seq

Overview:
Iterative, multi-cycle successor to the combinational mulxx. It computes (r0 * r1) >> shift with independent signedness per operand, one multiplier bit per clock, using a start/busy/done handshake. It sits beside the alu in processor as the execution unit for mul instructions, and lets the core stall on busy instead of paying a full-width combinational multiplier on the critical path.

Parameters:
WORD_SIZE, 18, operand and result width in bits (>= 4)
SHIFT_BITS, 6, width of the shift input; shift range 0 .. 2^SHIFT_BITS-1

Ports:
clock  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
start  input  1  request; sampled only when busy=0
r0  input  WORD_SIZE  multiplicand x, sampled on accepted start
r1  input  WORD_SIZE  multiplier y, sampled on accepted start
shift  input  SHIFT_BITS  right shift applied to full product, sampled on accepted start
signx  input  1  1: r0 is two's complement; 0: unsigned
signy  input  1  1: r1 is two's complement; 0: unsigned
busy  output  1  1 while an operation is in flight
done  output  1  one-cycle pulse when res becomes valid
res  output  WORD_SIZE  result, held stable until the next completion

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, res=0. All internal registers are cleared. An in-flight operation is discarded and produces no done.
- States: IDLE -> RUN -> FINISH -> IDLE.
  - IDLE: on rising edge with start=1, latch the operands and go to RUN. The following values are computed at latch:
    - magnitudes |x| and |y| as WORD_SIZE+1 bits, so -2^(WORD_SIZE-1) is exact;
    - neg = (signx & r0[MSB]) ^ (signy & r1[MSB]).
    - busy=1 from the next cycle.
  - RUN: exactly WORD_SIZE+1 cycles. Each cycle: if the multiplier LSB is 1, add |x| to the upper half of a 2*WORD_SIZE+2 bit accumulator, then shift the accumulator/multiplier right by one. A bit counter counts down from WORD_SIZE.
  - FINISH: one cycle.
    - Form P: the unsigned accumulator, negated if neg=1. P is a signed 2*WORD_SIZE+2 bit value.
    - res <= low WORD_SIZE bits of (P >>> shift), using an arithmetic shift, i.e. floor division by 2^shift.
    - done=1 for this one cycle; busy drops to 0 in the same cycle the done pulse is seen. Go to IDLE.
- Latency: start accepted at edge N gives done=1 and a valid res in the cycle after edge N+WORD_SIZE+2. Throughput is one operation per WORD_SIZE+3 cycles.
- Back-to-back: start=1 during the done cycle is accepted, because busy=0.
- start=1 while busy=1 is ignored; there is no queueing.
- Input changes on r0/r1/shift/signx/signy after acceptance have no effect.
- shift >= 2*WORD_SIZE+2: res = all zeros if P >= 0, all ones if P < 0.
- shift=0: res = low WORD_SIZE bits of P (wrap-around, no saturation).
- Zero operand: the operation still takes full latency; res=0.
- res changes only in FINISH or on reset. It is never X after reset.

Optional Feature:
MULXX_SEQ_ROUND_EN
- Defined: in FINISH, when shift > 0, res = low WORD_SIZE bits of ((P + 2^(shift-1)) >>> shift), i.e. round half up toward +inf. The addition is done at 2*WORD_SIZE+2 bits, so it has no overflow. When shift=0, behaviour is identical to the undefined case. Latency is unchanged.
- Undefined: truncating (floor) arithmetic shift only; no rounding adder is synthesised.

Test Plan:
- WORD_SIZE=18, unsigned, start with r0=2, r1=3, shift=0 -> busy rises next cycle; done pulses exactly 21 cycles after acceptance; res=6.
- Unsigned r0='h3ffff, r1='h3ffff, shift=18 -> res='h3fffe. Same with r1=37, shift=10 -> res='h24ff. r0=47273, r1=56782, shift=17 -> res='h4fff.
- Signed (signx=signy=1): r0=-1, r1=-1, shift=0 -> res=1. r0=-'hffff, r1='hffff, shift=16 -> res=-'hffff ('h30001). Mixed case r0=-2 (signx=1), r1=3 (signy=0) -> res=-6 ('h3fffa).
- Edge operands and shift range:
  - r0=-131072, r1=-131072, signed, shift=34 -> res=1;
  - same operands with shift=63 -> res=0;
  - r0=-1, r1=1, signed, shift=63 -> res='h3ffff.
- Handshake:
  - pulse start again mid-RUN -> ignored; res and latency unchanged.
  - assert start during the done cycle -> second operation accepted, with done 21 cycles later.
  - drop reset to 0 mid-RUN -> busy=0, done=0 and res=0 immediately, with no later done.
- With MULXX_SEQ_ROUND_EN: unsigned r0=3, r1=1, shift=1 -> res=2 (without the macro: 1). Signed r0=-3, r1=1, shift=1 -> res=-1 (without the macro: -2).

Source files
------------

// File: rtl/mulxx_seq.sv
// Iterative shift-add multiplier: (r0 * r1) >> shift with per-operand signedness,
// one multiplier bit per clock. Define MULXX_SEQ_ROUND_EN for round-half-up shifting.
module mulxx_seq #(
    parameter int unsigned WORD_SIZE  = 18,
    parameter int unsigned SHIFT_BITS = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_SIZE-1:0]  r0,
    input  logic [WORD_SIZE-1:0]  r1,
    input  logic [SHIFT_BITS-1:0] shift,
    input  logic                  signx,
    input  logic                  signy,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_SIZE-1:0]  res
);

    localparam int unsigned MW = WORD_SIZE + 1;
    localparam int unsigned AW = 2 * WORD_SIZE + 2;
    localparam int unsigned CW = $clog2(WORD_SIZE + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [AW-1:0]           r_acc;
    logic [MW-1:0]           r_mx;
    logic [SHIFT_BITS-1:0]   r_shift;
    logic                    r_neg;
    logic [CW-1:0]           r_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic [WORD_SIZE-1:0]    r_res;

    logic [MW-1:0]           w_x_ext;
    logic [MW-1:0]           w_y_ext;
    logic [MW-1:0]           w_x_mag;
    logic [MW-1:0]           w_y_mag;
    logic                    w_neg;
    logic [MW:0]             w_sum;
    logic [AW-1:0]           w_acc_nxt;
    logic signed [AW-1:0]    w_p;
    logic [WORD_SIZE-1:0]    w_res;

    // Operand magnitudes need one extra bit so -2^(WORD_SIZE-1) stays exact
    assign w_x_ext = {signx & r0[WORD_SIZE-1], r0};
    assign w_y_ext = {signy & r1[WORD_SIZE-1], r1};
    assign w_x_mag = w_x_ext[MW-1] ? (~w_x_ext + MW'(1)) : w_x_ext;
    assign w_y_mag = w_y_ext[MW-1] ? (~w_y_ext + MW'(1)) : w_y_ext;
    assign w_neg   = w_x_ext[MW-1] ^ w_y_ext[MW-1];

    // Upper half accumulates |x| when the current multiplier bit is set; carry shifts in
    assign w_sum     = {1'b0, r_acc[AW-1 -: MW]} + (r_acc[0] ? {1'b0, r_mx} : '0);
    assign w_acc_nxt = {w_sum, r_acc[MW-1:1]};

    assign w_p = r_neg ? (~r_acc + AW'(1)) : r_acc;

`ifdef MULXX_SEQ_ROUND_EN
    logic signed [AW:0] w_pe;
    logic signed [AW:0] w_half;

    assign w_pe   = {w_p[AW-1], w_p};
    assign w_half = ((r_shift != '0) && (32'(r_shift) < AW))
                    ? ((AW+1)'(1) << (r_shift - SHIFT_BITS'(1))) : '0;
    // Beyond the product width the rounded quotient is always zero
    assign w_res  = (32'(r_shift) >= AW) ? '0
                    : WORD_SIZE'((w_pe + w_half) >>> r_shift);
`else
    assign w_res  = WORD_SIZE'(w_p >>> r_shift);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_RUN;
            S_RUN:    if (r_cnt == '0) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_acc   <= '0;
            r_mx    <= '0;
            r_shift <= '0;
            r_neg   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_res   <= '0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= (r_state == S_FINISH);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc   <= {MW'(0), w_y_mag};
                        r_mx    <= w_x_mag;
                        r_shift <= shift;
                        r_neg   <= w_neg;
                        r_cnt   <= CW'(WORD_SIZE);
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FINISH: begin
                    r_res <= w_res;
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign res  = r_res;

endmodule

// File: tb/tb_mulxx_seq.sv
// Scoreboard bench for mulxx_seq: driver queues expected results, monitor checks each done.
module tb_mulxx_seq;

    localparam int unsigned W   = 18;
    localparam int unsigned SB  = 6;
    localparam int          LAT = 21;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  r0;
    logic [W-1:0]  r1;
    logic [SB-1:0] shift;
    logic          signx;
    logic          signy;
    logic          busy;
    logic          done;
    logic [W-1:0]  res;

    mulxx_seq #(.WORD_SIZE(W), .SHIFT_BITS(SB)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .r0    (r0),
        .r1    (r1),
        .shift (shift),
        .signx (signx),
        .signy (signy),
        .busy  (busy),
        .done  (done),
        .res   (res)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int           due;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact integer product, optional half-up rounding, floor shift
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [SB-1:0] s, input logic sx, input logic sy);
        longint x, y, p;
        x = sx ? longint'($signed(a)) : longint'(a);
        y = sy ? longint'($signed(b)) : longint'(b);
        p = x * y;
`ifdef MULXX_SEQ_ROUND_EN
        if (s != 0) p = p + (longint'(1) <<< (int'(s) - 1));
`endif
        p = p >>> s;
        return W'(p);
    endfunction

    // Monitor: every done must match the oldest outstanding expectation, on time
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (done) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("res", 64'(res), 64'(e.res));
                    check("done_cycle", 64'(cyc), 64'(e.due));
                    check("busy_in_done", 64'(busy), 64'(0));
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
                exp_t e;
                e = sbq.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missing_done: got none expected done at cycle %0d (now %0d)", e.due, cyc);
            end
        end
    end

    task automatic wait_idle(input int extra);
        int t = 0;
        while (busy && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'(0));
        repeat (extra) @(negedge clock);
    endtask

    // Drive one request at a negedge where busy=0; returns one cycle later
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SB-1:0] s, input logic sx, input logic sy);
        exp_t e;
        wait_idle(0);
        r0 = a; r1 = b; shift = s; signx = sx; signy = sy;
        start = 1'b1;
        e.res = model(a, b, s, sx, sy);
        e.due = cyc + LAT;
        sbq.push_back(e);
        @(negedge clock);
        start = 1'b0;
        r0 = W'($urandom); r1 = W'($urandom); shift = SB'($urandom);
        signx = 1'($urandom); signy = 1'($urandom);
        check("busy_rise", 64'(busy), 64'(1));
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return W'(18'h20000);
            2:       return W'(18'h3ffff);
            3:       return W'(1);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        start = 1'b0; r0 = '0; r1 = '0; shift = '0; signx = 1'b0; signy = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_res",  64'(res),  64'(0));
        reset = 1'b1;
        @(negedge clock);

        // Directed cases, issued back-to-back (start lands in each done cycle)
        issue(18'd2,      18'd3,      6'd0,  1'b0, 1'b0);
        issue(18'h3ffff,  18'h3ffff,  6'd18, 1'b0, 1'b0);
        issue(18'h3ffff,  18'd37,     6'd10, 1'b0, 1'b0);
        issue(18'd47273,  18'd56782,  6'd17, 1'b0, 1'b0);
        issue(18'h3ffff,  18'h3ffff,  6'd0,  1'b1, 1'b1);
        issue(18'h30001,  18'h0ffff,  6'd16, 1'b1, 1'b1);
        issue(18'h3fffe,  18'd3,      6'd0,  1'b1, 1'b0);
        issue(18'h20000,  18'h20000,  6'd34, 1'b1, 1'b1);
        issue(18'h20000,  18'h20000,  6'd63, 1'b1, 1'b1);
        issue(18'h3ffff,  18'd1,      6'd63, 1'b1, 1'b1);
        issue(18'd0,      18'd12345,  6'd0,  1'b0, 1'b0);
        issue(18'd3,      18'd1,      6'd1,  1'b0, 1'b0);
        issue(18'h3fffd,  18'd1,      6'd1,  1'b1, 1'b1);
        issue(18'h3ffff,  18'h3ffff,  6'd37, 1'b0, 1'b0);

        // Start pulses while busy must be ignored
        issue(18'd1000, 18'd999, 6'd3, 1'b0, 1'b0);
        repeat (5) @(negedge clock);
        r0 = W'($urandom); r1 = W'($urandom); shift = SB'($urandom);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;

        // Randomised traffic with random idle gaps
        for (int i = 0; i < 150; i++) begin
            logic [SB-1:0] s;
            s = ($urandom_range(0, 3) == 0) ? SB'($urandom) : SB'($urandom_range(0, 40));
            issue(rand_op(), rand_op(), s, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) wait_idle($urandom_range(1, 4));
        end

        // Asynchronous reset mid-operation discards it
        issue(18'h12345, 18'h00777, 6'd0, 1'b0, 1'b0);
        wait_idle(2);
        issue(18'h0abcd, 18'h01234, 6'd2, 1'b0, 1'b0);
        repeat (6) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("midrun_reset_busy", 64'(busy), 64'(0));
        check("midrun_reset_done", 64'(done), 64'(0));
        check("midrun_reset_res",  64'(res),  64'(0));
        sbq.delete();
        @(negedge clock);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        check("post_reset_idle", 64'(busy), 64'(0));

        // One more operation after reset recovery
        issue(18'd77, 18'd55, 6'd1, 1'b0, 1'b0);
        begin
            int t = 0;
            while (sbq.size() > 0 && t < 200) begin
                @(negedge clock);
                t++;
            end
        end
        if (sbq.size() > 0) begin
            check("drain_timeout", 64'(sbq.size()), 64'(0));
            sbq.delete();
        end
        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
